axi_lite_master: RTL and testbench

- AXI4-Lite master bus engine directly downstream of the memory-access stage peripheral controller.
- Consumes single-cycle StartAXIRead/StartAXIWrite requests plus address and data.
- Runs one 32-bit AXI4-Lite transaction at a time.
- Returns ReadCompleted/WriteCompleted pulses, which release the pipeline stall, and read data to the MEM stage.

---
 rtl/axi_lite_pkg.sv | 26 ++
 rtl/axi_lite_master.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: FSM state encoding, response codes
// and default bus widths.
package axi_lite_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_DONE
  } state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master serving the MEM-stage peripheral controller.
// Optional slave-response watchdog enabled by defining AXI_TIMEOUT_EN.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = AXI_ADDR_W,
  parameter int unsigned DATA_W         = AXI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                StartAXIRead,
  input  logic                StartAXIWrite,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   WData,
  input  logic [DATA_W/8-1:0] WStrb,
  output logic                ReadCompleted,
  output logic                WriteCompleted,
  output logic [DATA_W-1:0]   RData,
  output logic                BusError,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  output logic [ADDR_W-1:0]   M_ARADDR,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  input  logic [DATA_W-1:0]   M_RDATA,
  input  logic [1:0]          M_RRESP,
  input  logic                M_RVALID,
  output logic                M_RREADY
);

  if (DATA_W != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axi_lite_master: DATA_W must be 32 and TIMEOUT_CYCLES at least 2");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                wr_done_q, wr_done_d;
  logic                rd_done_q, rd_done_d;
  logic                bus_err_q, bus_err_d;

`ifdef AXI_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    bus_err_d = bus_err_q;

    unique case (state_q)
      ST_IDLE: begin
        // Write has priority when both starts arrive together.
        if (StartAXIWrite) begin
          state_d   = ST_WR_REQ;
          addr_d    = Address;
          wdata_d   = WData;
          wstrb_d   = WStrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bus_err_d = 1'b0;
        end else if (StartAXIRead) begin
          state_d   = ST_RD_REQ;
          addr_d    = Address;
          arvalid_d = 1'b1;
          bus_err_d = 1'b0;
        end
      end
      ST_WR_REQ: begin
        if (awvalid_q && M_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (M_BVALID) begin
          state_d   = ST_DONE;
          bready_d  = 1'b0;
          bus_err_d = resp_is_err(M_BRESP);
          wr_done_d = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (M_ARREADY) begin
          state_d   = ST_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (M_RVALID) begin
          state_d   = ST_DONE;
          rready_d  = 1'b0;
          rdata_d   = M_RDATA;
          bus_err_d = resp_is_err(M_RRESP);
          rd_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef AXI_TIMEOUT_EN
    busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    cnt_d = busy ? cnt_q + CNT_W'(1) : '0;
    // Watchdog overrides any handshake landing in the same cycle.
    if (busy && cnt_q == CNT_LAST) begin
      state_d   = ST_DONE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rdata_d   = rdata_q;
      bus_err_d = 1'b1;
      wr_done_d = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP);
      rd_done_d = (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    end
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef AXI_TIMEOUT_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign M_AWADDR       = addr_q;
  assign M_ARADDR       = addr_q;
  assign M_WDATA        = wdata_q;
  assign M_WSTRB        = wstrb_q;
  assign M_AWVALID      = awvalid_q;
  assign M_WVALID       = wvalid_q;
  assign M_BREADY       = bready_q;
  assign M_ARVALID      = arvalid_q;
  assign M_RREADY       = rready_q;
  assign WriteCompleted = wr_done_q;
  assign ReadCompleted  = rd_done_q;
  assign BusError       = bus_err_q;
  assign RData          = rdata_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a scripted slave plus a timing model that
// derives every expected output from each transaction's handshake latencies.
module tb_axi_lite_master;

  localparam int TO = 16;
`ifdef AXI_TIMEOUT_EN
  localparam int TLIM = TO;
`else
  localparam int TLIM = 1 << 30;
`endif

  logic        Clk, Rst;
  logic        StartAXIRead, StartAXIWrite;
  logic [31:0] Address, WData;
  logic [3:0]  WStrb;
  logic        ReadCompleted, WriteCompleted, BusError;
  logic [31:0] RData;
  logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
  logic [3:0]  M_WSTRB;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
  logic [1:0]  M_BRESP, M_RRESP;
  logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .StartAXIRead(StartAXIRead), .StartAXIWrite(StartAXIWrite),
    .Address(Address), .WData(WData), .WStrb(WStrb),
    .ReadCompleted(ReadCompleted), .WriteCompleted(WriteCompleted),
    .RData(RData), .BusError(BusError),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          l0;
    int          l1;
    int          l2;
    logic        busy_wr;
    int          abort;
  } txn_t;

  int total = 0;
  int bad = 0;

  txn_t        cur;
  logic        active = 1'b0;
  logic        is_wr, to;
  int          t0, ta, tw, tb0, tfin, tdone;
  logic [31:0] model_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] ctl_vec();
    return {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, WriteCompleted, ReadCompleted};
  endfunction

  function automatic txn_t mk(logic wr, logic rd, logic [31:0] addr, logic [31:0] data,
                              logic [3:0] strb, logic [1:0] resp, logic [31:0] rdata,
                              int l0, int l1, int l2, logic busy_wr, int abort);
    txn_t t;
    t.wr = wr; t.rd = rd; t.addr = addr; t.data = data; t.strb = strb;
    t.resp = resp; t.rdata = rdata; t.l0 = l0; t.l1 = l1; t.l2 = l2;
    t.busy_wr = busy_wr; t.abort = abort;
    return t;
  endfunction

  // Event cycles relative to the start cycle (0), given the slave latencies.
  task automatic plan(input txn_t t);
    is_wr = t.wr;
    if (t.wr) begin
      ta   = 1 + t.l0;
      tw   = 1 + t.l1;
      tb0  = ((ta > tw) ? ta : tw) + 1;
      tfin = tb0 + t.l2;
    end else begin
      ta   = 1 + t.l0;
      tw   = 0;
      tb0  = ta + 1;
      tfin = tb0 + t.l1;
    end
    to    = (tfin >= TLIM);
    tdone = (to ? TLIM : tfin) + 1;
  endtask

  // Compare process: every cycle, 1 time unit after the rising edge.
  always @(posedge Clk) begin : cmp
    int c;
    logic [6:0] e;
    #1;
    if (!Rst) begin
      if (active) begin
        c = cyc - t0;
        e[6] = is_wr && c >= 1 && c <= ta && c < tdone;
        e[5] = is_wr && c >= 1 && c <= tw && c < tdone;
        e[4] = is_wr && c >= tb0 && c <= tfin && c < tdone;
        e[3] = !is_wr && c >= 1 && c <= ta && c < tdone;
        e[2] = !is_wr && c >= tb0 && c <= tfin && c < tdone;
        e[1] = is_wr && c == tdone;
        e[0] = !is_wr && c == tdone;
        chk("ctl", ctl_vec(), e);
        chk("rdata", RData, (!is_wr && !to && c >= tdone) ? cur.rdata : model_rdata);
        if (e[6]) chk("awaddr", M_AWADDR, cur.addr);
        if (e[5]) chk("wdata_strb", {M_WSTRB, M_WDATA}, {cur.strb, cur.data});
        if (e[3]) chk("araddr", M_ARADDR, cur.addr);
        if (c == tdone) chk("buserr", BusError, to || cur.resp[1]);
      end else begin
        chk("idle_ctl", ctl_vec(), 7'd0);
        chk("idle_rdata", RData, model_rdata);
      end
    end
  end

  task automatic clear_inputs();
    StartAXIRead = 0; StartAXIWrite = 0;
    Address = '0; WData = '0; WStrb = '0;
    M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 2'b00;
    M_ARREADY = 0; M_RVALID = 0; M_RRESP = 2'b00; M_RDATA = '0;
  endtask

  task automatic drive(input int c, input txn_t t);
    StartAXIWrite = (c == 0 && t.wr) || (c == 2 && t.busy_wr);
    StartAXIRead  = (c == 0 && t.rd);
    Address = (c == 0) ? t.addr : 32'hFFFF_FFFF;
    WData   = (c == 0) ? t.data : 32'hFFFF_FFFF;
    WStrb   = (c == 0) ? t.strb : 4'hF;
    if (t.wr) begin
      M_AWREADY = (c >= ta);
      M_WREADY  = (c >= tw);
      M_BVALID  = (c == tfin);
      M_BRESP   = (c == tfin) ? t.resp : 2'b00;
    end else begin
      M_ARREADY = (c >= ta);
      M_RVALID  = (c == tfin);
      M_RRESP   = (c == tfin) ? t.resp : 2'b00;
      M_RDATA   = (c == tfin) ? t.rdata : 32'hBAD0_BAD0;
    end
  endtask

  // Hand-computed expectations pinning the timing model on selected tests.
  task automatic lit(input int idx, input int c);
    case (idx)
      0: begin
        if (c == 1) chk("t0_avw_c1", {M_AWVALID, M_WVALID}, 2'b11);
        if (c == 2) chk("t0_c2", {M_AWVALID, M_WVALID, M_BREADY}, 3'b001);
        if (c == 3) chk("t0_done_c3", {WriteCompleted, BusError}, 2'b10);
        if (c == 4) chk("t0_pulse_end", WriteCompleted, 1'b0);
      end
      1: begin
        if (c == 4) chk("t1_arvalid_c4", M_ARVALID, 1'b1);
        if (c == 8) chk("t1_done_c8", {ReadCompleted, BusError, RData}, {2'b10, 32'h1234_5678});
      end
      2: begin
        if (c == 2) chk("t2_c2", {M_AWVALID, M_WVALID}, 2'b10);
        if (c == 5) chk("t2_c5", {M_AWVALID, M_BREADY}, 2'b01);
        if (c == 6) chk("t2_done_c6", WriteCompleted, 1'b1);
      end
      3: if (c == 3) chk("t3_err_c3", {ReadCompleted, BusError}, 2'b11);
`ifdef AXI_TIMEOUT_EN
      9: begin
        if (c == 16) chk("t9_arvalid_c16", M_ARVALID, 1'b1);
        if (c == 17) chk("t9_timeout_c17", {M_ARVALID, ReadCompleted, BusError, RData},
                         {3'b011, 32'hA5A5_5A5A});
      end
`endif
      default: ;
    endcase
  endtask

  task automatic run_txn(input txn_t t, input int idx);
    plan(t);
    @(negedge Clk);
    t0 = cyc;
    cur = t;
    active = 1'b1;
    for (int c = 0; c <= tdone; c++) begin
      if (c > 0) @(negedge Clk);
      if (t.abort != 0 && c == t.abort) begin
        Rst = 1'b1;
        #1;
        chk("rst_ctl", ctl_vec(), 7'd0);
        chk("rst_rdata_berr", {BusError, RData}, 33'd0);
        active = 1'b0;
        model_rdata = '0;
        clear_inputs();
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
      lit(idx, c);
      drive(c, t);
    end
    active = 1'b0;
    if (!t.wr && !to) model_rdata = t.rdata;
    clear_inputs();
  endtask

  txn_t tests[10];

  initial begin
    tests[0] = mk(1, 0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0, 0, 0, 0, 0, 0);
    tests[1] = mk(0, 1, 32'h4000_0020, 32'h0, 4'h0, 2'b00, 32'h1234_5678, 3, 2, 0, 0, 0);
    tests[2] = mk(1, 0, 32'h4000_0030, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0, 3, 0, 0, 0, 0);
    tests[3] = mk(0, 1, 32'h4000_0040, 32'h0, 4'h0, 2'b10, 32'h0BAD_F00D, 0, 0, 0, 1, 0);
    tests[4] = mk(1, 1, 32'h4000_0050, 32'h1122_3344, 4'hC, 2'b11, 32'h0, 1, 1, 2, 0, 0);
    tests[5] = mk(1, 0, 32'h4000_0060, 32'h5566_7788, 4'h3, 2'b01, 32'h0, 0, 2, 1, 0, 0);
    tests[6] = mk(0, 1, 32'h4000_0070, 32'h0, 4'h0, 2'b00, 32'h9999_9999, 0, 20, 0, 0, 4);
    tests[7] = mk(0, 1, 32'h4000_0080, 32'h0, 4'h0, 2'b00, 32'hA5A5_5A5A, 1, 1, 0, 0, 0);
    tests[8] = mk(1, 0, 32'h4000_0090, 32'h0F0F_0F0F, 4'h1, 2'b00, 32'h0, 2, 2, 0, 0, 0);
`ifdef AXI_TIMEOUT_EN
    tests[9] = mk(0, 1, 32'h4000_00A0, 32'h0, 4'h0, 2'b00, 32'h7777_7777, 100, 0, 0, 0, 0);
`else
    tests[9] = mk(0, 1, 32'h4000_00A0, 32'h0, 4'h0, 2'b00, 32'h7777_7777, 30, 3, 0, 0, 0);
`endif

    Rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge Clk);
    chk("reset_ctl", ctl_vec(), 7'd0);
    chk("reset_rdata_berr", {BusError, RData}, 33'd0);
    Rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tests[i], i);

    repeat (4) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got no end want end");
    $fatal(1, "watchdog expired");
  end

endmodule
